vga_color_sequencer: RTL and testbench

//  Colour-select controller between the NEXT/PREV push buttons and the VGA

---
 rtl/vga_color_pkg.sv | 28 ++
 rtl/vga_color_sequencer_if.sv | 22 ++
 rtl/vga_color_sequencer_debounce.sv | 46 ++++
 rtl/vga_color_sequencer.sv | 73 +++++++
 tb/tb_vga_color_sequencer.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_color_pkg.sv
// Shared constants for the VGA colour sequencer: bus widths, named colours
// and the fixed 8-entry palette indexed by the applied colour index.
package vga_color_pkg;

  localparam int RGB_W = 12;
  localparam int IDX_W = 3;
  localparam int PALETTE_DEPTH = 8;

  localparam logic [RGB_W-1:0] COLOR_BLACK   = 12'h000;
  localparam logic [RGB_W-1:0] COLOR_RED     = 12'hF00;
  localparam logic [RGB_W-1:0] COLOR_GREEN   = 12'h0F0;
  localparam logic [RGB_W-1:0] COLOR_BLUE    = 12'h00F;
  localparam logic [RGB_W-1:0] COLOR_YELLOW  = 12'hFF0;
  localparam logic [RGB_W-1:0] COLOR_CYAN    = 12'h0FF;
  localparam logic [RGB_W-1:0] COLOR_MAGENTA = 12'hF0F;
  localparam logic [RGB_W-1:0] COLOR_WHITE   = 12'hFFF;

  // Packed so that PALETTE[0] is the rightmost entry (black).
  localparam logic [PALETTE_DEPTH-1:0][RGB_W-1:0] PALETTE = {
    COLOR_WHITE, COLOR_MAGENTA, COLOR_CYAN, COLOR_YELLOW,
    COLOR_BLUE,  COLOR_GREEN,   COLOR_RED,  COLOR_BLACK
  };

  function automatic logic [RGB_W-1:0] palette_lookup(input logic [IDX_W-1:0] idx);
    return PALETTE[idx];
  endfunction

endpackage

// File: rtl/vga_color_sequencer_if.sv
// Button/frame inputs and applied-colour outputs of the colour sequencer.
interface vga_color_sequencer_if;
  import vga_color_pkg::*;

  logic             BTN_NEXT;
  logic             BTN_PREV;
  logic             frame_start;
  logic [IDX_W-1:0] color_idx;
  logic [RGB_W-1:0] rgb;
  logic             pending;

  modport master (
    output BTN_NEXT, BTN_PREV, frame_start,
    input  color_idx, rgb, pending
  );

  modport slave (
    input  BTN_NEXT, BTN_PREV, frame_start,
    output color_idx, rgb, pending
  );

endinterface

// File: rtl/vga_color_sequencer_debounce.sv
// Per-button 2-FF synchroniser, stability counter and press (rising-edge) pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_level;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // The counter only advances while the synced level disagrees with the
  // accepted level; any agreement throws the partial count away.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta  <= 1'b0;
      sync_level <= 1'b0;
      level      <= 1'b0;
      level_d    <= 1'b0;
      cnt        <= '0;
    end else begin
      sync_meta  <= btn_raw;
      sync_level <= sync_meta;
      level_d    <= level;
      if (sync_level == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/vga_color_sequencer.sv
// Steps a pending palette index from debounced NEXT/PREV presses and applies it
// to the VGA colour only on frame_start, so colour never changes mid-frame.
module vga_color_sequencer
  import vga_color_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int NUM_COLORS      = 8
) (
  input  logic                  CLK50MHZ,
  input  logic                  RST,
  vga_color_sequencer_if.slave  color_bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COLORS - 1);

  logic             next_press;
  logic             prev_press;
  logic [IDX_W-1:0] pidx;
  logic [IDX_W-1:0] pidx_next;
  logic [IDX_W-1:0] color_idx_q;
  logic [IDX_W-1:0] color_idx_next;
  logic [RGB_W-1:0] rgb_q;
  logic             pending_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk     (CLK50MHZ),
    .rst     (RST),
    .btn_raw (color_bus.BTN_NEXT),
    .press   (next_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
    .clk     (CLK50MHZ),
    .rst     (RST),
    .btn_raw (color_bus.BTN_PREV),
    .press   (prev_press)
  );

  // Simultaneous NEXT and PREV cancel out.
  always_comb begin
    pidx_next = pidx;
    if (next_press && !prev_press) begin
      pidx_next = (pidx == LAST_IDX) ? '0 : pidx + 1'b1;
    end else if (prev_press && !next_press) begin
      pidx_next = (pidx == '0) ? LAST_IDX : pidx - 1'b1;
    end
  end

  assign color_idx_next = color_bus.frame_start ? pidx : color_idx_q;

  // Commit takes the pre-press pidx; pending is formed from the post-edge
  // values so it tracks pidx/color_idx without an extra cycle of lag.
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      pidx        <= '0;
      color_idx_q <= '0;
      rgb_q       <= COLOR_BLACK;
      pending_q   <= 1'b0;
    end else begin
      pidx <= pidx_next;
      if (color_bus.frame_start) begin
        color_idx_q <= pidx;
        rgb_q       <= palette_lookup(pidx);
      end
      pending_q <= (pidx_next != color_idx_next);
    end
  end

  assign color_bus.color_idx = color_idx_q;
  assign color_bus.rgb       = rgb_q;
  assign color_bus.pending   = pending_q;

endmodule

// File: tb/tb_vga_color_sequencer.sv
// Directed bench for vga_color_sequencer: 8-colour and 5-colour instances
// driven in lockstep, a vector table plus hand sequences for timing corners.
module tb_vga_color_sequencer;

  logic clk;
  logic rst;
  int   check_count;
  int   pass_count;

  vga_color_sequencer_if bus8 ();
  vga_color_sequencer_if bus5 ();

  vga_color_sequencer #(.DEBOUNCE_CYCLES(4), .NUM_COLORS(8)) dut8 (
    .CLK50MHZ  (clk),
    .RST       (rst),
    .color_bus (bus8)
  );

  vga_color_sequencer #(.DEBOUNCE_CYCLES(4), .NUM_COLORS(5)) dut5 (
    .CLK50MHZ  (clk),
    .RST       (rst),
    .color_bus (bus5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {OP_RESET, OP_NEXT, OP_PREV, OP_BOTH, OP_FRAME} op_e;

  typedef struct {
    op_e         op;
    logic [2:0]  idx8;
    logic [11:0] rgb8;
    logic        pend8;
    logic [2:0]  idx5;
    logic [11:0] rgb5;
    logic        pend5;
  } vec_t;

  vec_t vecs [20];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setInputs(input logic next, input logic prev, input logic frame);
    bus8.BTN_NEXT = next;  bus5.BTN_NEXT = next;
    bus8.BTN_PREV = prev;  bus5.BTN_PREV = prev;
    bus8.frame_start = frame;  bus5.frame_start = frame;
  endtask

  task automatic checkOutput(input string name, input logic [11:0] actual,
                             input logic [11:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic checkState(input string tag, input logic [2:0] idx8, input logic [11:0] rgb8,
                            input logic pend8, input logic [2:0] idx5,
                            input logic [11:0] rgb5, input logic pend5);
    checkOutput({tag, " idx8"},  12'(bus8.color_idx), 12'(idx8));
    checkOutput({tag, " rgb8"},  bus8.rgb,            rgb8);
    checkOutput({tag, " pend8"}, 12'(bus8.pending),   12'(pend8));
    checkOutput({tag, " idx5"},  12'(bus5.color_idx), 12'(idx5));
    checkOutput({tag, " rgb5"},  bus5.rgb,            rgb5);
    checkOutput({tag, " pend5"}, 12'(bus5.pending),   12'(pend5));
  endtask

  task automatic doReset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  task automatic pressButtons(input logic next, input logic prev);
    setInputs(next, prev, 1'b0);
    repeat (10) tick();
    setInputs(1'b0, 1'b0, 1'b0);
    repeat (10) tick();
  endtask

  task automatic pulseFrame();
    setInputs(1'b0, 1'b0, 1'b1);
    tick();
    setInputs(1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic applyStimulus(input op_e op);
    case (op)
      OP_RESET: begin doReset(2); tick(); end
      OP_NEXT:  pressButtons(1'b1, 1'b0);
      OP_PREV:  pressButtons(1'b0, 1'b1);
      OP_BOTH:  pressButtons(1'b1, 1'b1);
      OP_FRAME: pulseFrame();
      default:  tick();
    endcase
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    setInputs(1'b0, 1'b0, 1'b0);

    vecs[0]  = '{OP_RESET, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000, 1'b0};
    vecs[1]  = '{OP_PREV,  3'd0, 12'h000, 1'b1, 3'd0, 12'h000, 1'b1};
    vecs[2]  = '{OP_FRAME, 3'd7, 12'hFFF, 1'b0, 3'd4, 12'hFF0, 1'b0};
    vecs[3]  = '{OP_NEXT,  3'd7, 12'hFFF, 1'b1, 3'd4, 12'hFF0, 1'b1};
    vecs[4]  = '{OP_NEXT,  3'd7, 12'hFFF, 1'b1, 3'd4, 12'hFF0, 1'b1};
    vecs[5]  = '{OP_FRAME, 3'd1, 12'hF00, 1'b0, 3'd1, 12'hF00, 1'b0};
    vecs[6]  = '{OP_FRAME, 3'd1, 12'hF00, 1'b0, 3'd1, 12'hF00, 1'b0};
    vecs[7]  = '{OP_RESET, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000, 1'b0};
    vecs[8]  = '{OP_NEXT,  3'd0, 12'h000, 1'b1, 3'd0, 12'h000, 1'b1};
    vecs[9]  = '{OP_NEXT,  3'd0, 12'h000, 1'b1, 3'd0, 12'h000, 1'b1};
    vecs[10] = '{OP_NEXT,  3'd0, 12'h000, 1'b1, 3'd0, 12'h000, 1'b1};
    vecs[11] = '{OP_FRAME, 3'd3, 12'h00F, 1'b0, 3'd3, 12'h00F, 1'b0};
    vecs[12] = '{OP_BOTH,  3'd3, 12'h00F, 1'b0, 3'd3, 12'h00F, 1'b0};
    vecs[13] = '{OP_PREV,  3'd3, 12'h00F, 1'b1, 3'd3, 12'h00F, 1'b1};
    vecs[14] = '{OP_BOTH,  3'd3, 12'h00F, 1'b1, 3'd3, 12'h00F, 1'b1};
    vecs[15] = '{OP_FRAME, 3'd2, 12'h0F0, 1'b0, 3'd2, 12'h0F0, 1'b0};
    vecs[16] = '{OP_NEXT,  3'd2, 12'h0F0, 1'b1, 3'd2, 12'h0F0, 1'b1};
    vecs[17] = '{OP_NEXT,  3'd2, 12'h0F0, 1'b1, 3'd2, 12'h0F0, 1'b1};
    vecs[18] = '{OP_NEXT,  3'd2, 12'h0F0, 1'b1, 3'd2, 12'h0F0, 1'b1};
    vecs[19] = '{OP_FRAME, 3'd5, 12'h0FF, 1'b0, 3'd0, 12'h000, 1'b0};

    // Reset, then idle with buttons low.
    doReset(3);
    for (int k = 0; k < 20; k++) begin
      tick();
      checkState($sformatf("idle%0d", k), 3'd0, 12'h000, 1'b0, 3'd0, 12'h000, 1'b0);
    end

    // Press latency: pending must rise exactly 7 cycles after the raw edge.
    setInputs(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      checkOutput($sformatf("lat8 c%0d", k), 12'(bus8.pending), 12'(k >= 7));
      checkOutput($sformatf("lat5 c%0d", k), 12'(bus5.pending), 12'(k >= 7));
    end
    setInputs(1'b1, 1'b0, 1'b1);
    tick();
    setInputs(1'b1, 1'b0, 1'b0);
    checkState("commit1", 3'd1, 12'hF00, 1'b0, 3'd1, 12'hF00, 1'b0);
    setInputs(1'b0, 1'b0, 1'b0);
    repeat (10) tick();

    // Bounce shorter than the debounce window is discarded.
    for (int k = 0; k < 20; k++) begin
      setInputs(((k / 2) % 2) == 0, 1'b0, 1'b0);
      tick();
      checkOutput($sformatf("bounce idx c%0d", k), 12'(bus8.color_idx), 12'd1);
      checkOutput($sformatf("bounce pend c%0d", k), 12'(bus8.pending), 12'd0);
    end
    setInputs(1'b0, 1'b0, 1'b0);
    repeat (10) tick();
    checkState("bounce end", 3'd1, 12'hF00, 1'b0, 3'd1, 12'hF00, 1'b0);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].op);
      checkState($sformatf("vec%0d", i), vecs[i].idx8, vecs[i].rgb8, vecs[i].pend8,
                 vecs[i].idx5, vecs[i].rgb5, vecs[i].pend5);
    end

    // Press pulse coincident with frame_start: old pidx is what gets applied.
    pressButtons(1'b0, 1'b1);
    checkState("pre coinc", 3'd5, 12'h0FF, 1'b1, 3'd0, 12'h000, 1'b1);
    setInputs(1'b1, 1'b0, 1'b0);
    repeat (6) tick();
    setInputs(1'b1, 1'b0, 1'b1);
    tick();
    setInputs(1'b1, 1'b0, 1'b0);
    checkState("coinc commit", 3'd4, 12'hFF0, 1'b1, 3'd4, 12'hFF0, 1'b1);
    tick();
    checkState("coinc hold", 3'd4, 12'hFF0, 1'b1, 3'd4, 12'hFF0, 1'b1);
    setInputs(1'b0, 1'b0, 1'b0);
    repeat (10) tick();
    checkState("coinc idle", 3'd4, 12'hFF0, 1'b1, 3'd4, 12'hFF0, 1'b1);
    pulseFrame();
    checkState("coinc next", 3'd5, 12'h0FF, 1'b0, 3'd0, 12'h000, 1'b0);

    // Reset in the middle of a debounce with the button still held.
    setInputs(1'b1, 1'b0, 1'b0);
    repeat (2) tick();
    doReset(2);
    checkState("mid rst", 3'd0, 12'h000, 1'b0, 3'd0, 12'h000, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      checkOutput($sformatf("rst lat8 c%0d", k), 12'(bus8.pending), 12'(k >= 7));
      checkOutput($sformatf("rst lat5 c%0d", k), 12'(bus5.pending), 12'(k >= 7));
    end
    setInputs(1'b0, 1'b0, 1'b0);
    repeat (10) tick();
    pulseFrame();
    checkState("post rst", 3'd1, 12'hF00, 1'b0, 3'd1, 12'hF00, 1'b0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
